// File: rtl/spi_adc_responder.sv
// SPI mode-0 responder that stands in for a 12-bit serial ADC.
// SPI pins are oversampled in the clk domain; each CS frame returns {zeros, sample} and captures MOSI.
module spi_adc_responder #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_BITS-1:0]  sample_in,
  input  logic                  sample_load,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CW = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_last_q, sck_last_d;
  logic                   cs_last_q, cs_last_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  tx_q, tx_d;
  logic [FRAME_BITS-1:0]  rx_sh_q, rx_sh_d;
  logic [FRAME_BITS-1:0]  rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [FRAME_BITS-1:0]  tx_load;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_last_q;
  assign sck_fall = ~sck_s & sck_last_q;
  assign cs_rise  = cs_s & ~cs_last_q;
  assign cs_fall  = ~cs_s & cs_last_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_last_d  = sck_s;
    cs_last_d   = cs_s;
    hold_d      = sample_load ? sample_in : hold_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = busy_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    tx_load     = '0;
    tx_load[DATA_BITS-1:0] = sample_load ? sample_in : hold_q;

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (cs_fall) begin
          tx_d      = tx_load;
          miso_d    = tx_load[FRAME_BITS-1];
          miso_oe_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // CS wins over a coincident SCK edge; any early rise is an abort.
        if (cs_rise) begin
          frame_err_d = 1'b1;
          busy_d      = 1'b0;
          miso_oe_d   = 1'b0;
          miso_d      = 1'b0;
          state_d     = IDLE;
        end else if (sck_rise) begin
          rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], mosi_s};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_d == CW'(FRAME_BITS)) begin
            rx_data_d  = rx_sh_d;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
            state_d    = DONE;
          end
        end else if (sck_fall) begin
          tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
          miso_d = tx_q[FRAME_BITS-2];
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          busy_d    = 1'b0;
          miso_oe_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // cs sync resets low so a CS already asserted at release never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_last_q  <= 1'b0;
      cs_last_q   <= 1'b0;
      hold_q      <= '0;
      cnt_q       <= '0;
      tx_q        <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_last_q  <= sck_last_d;
      cs_last_q   <= cs_last_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Testbench for spi_adc_responder: behavioural SPI master, ADC model and event scoreboard.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, cs_n, mosi;
  logic        miso, miso_oe;
  logic [11:0] sample_in;
  logic        sample_load;
  logic [15:0] rx_data;
  logic        rx_valid, busy, frame_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } ev_t;
  ev_t exp_q[$];

  logic [11:0] hold_m;
  logic [15:0] rx_data_m;

  spi_adc_responder dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .sample_in(sample_in), .sample_load(sample_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rx_valid / frame_err pulse must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n && (rx_valid || frame_err)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: rx_valid=%0b frame_err=%0b rx_data=%h", rx_valid, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.is_err || rx_valid !== !e.is_err || (!e.is_err && rx_data !== e.data)) begin
          miscompares++;
          $display("FAIL event: got valid=%0b err=%0b data=%h expected err=%0b data=%h",
                   rx_valid, frame_err, rx_data, e.is_err, e.data);
        end
      end
    end
  end

  task automatic load(input logic [11:0] v);
    @(negedge clk);
    sample_in   = v;
    sample_load = 1'b1;
    @(negedge clk);
    sample_load = 1'b0;
    hold_m      = v;
  endtask

  // Mode-0 master, SCK = clk/10. load_bit: -1 none, -2 coincident with CS fall, k during bit k.
  task automatic spi_frame(input logic [31:0] mo, input int nbits, input int load_bit,
                           input logic [11:0] load_val, output logic [31:0] got, output bit busy_ok);
    got = '0;
    busy_ok = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      sample_load = (load_bit == -2 && j == 1);
      if (sample_load) sample_in = load_val;
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[nbits-1-i];
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        sample_load = (load_bit == i && j == 0);
        if (sample_load) sample_in = load_val;
      end
      got = {got[30:0], miso};
      if (busy !== 1'b1 || miso_oe !== 1'b1) busy_ok = 1'b0;
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Reference: frame returns {4'b0, sample} MSB first followed by zeros; first 16 MOSI bits are captured.
  task automatic frame_check(input string tag, input logic [31:0] mo, input int nbits,
                             input int load_bit, input logic [11:0] load_val);
    logic [11:0] smp;
    logic [31:0] exp_word, got;
    bit          busy_ok;
    ev_t         e;
    smp = (load_bit == -2) ? load_val : hold_m;
    if (nbits >= 16) begin
      exp_word  = 32'(smp) << (nbits - 16);
      e.is_err  = 1'b0;
      e.data    = mo[nbits-1 -: 16];
      rx_data_m = e.data;
    end else begin
      exp_word = 32'(smp) >> (16 - nbits);
      e.is_err = 1'b1;
      e.data   = '0;
    end
    exp_q.push_back(e);
    if (load_bit != -1) hold_m = load_val;
    spi_frame(mo, nbits, load_bit, load_val, got, busy_ok);
    check({tag, "_miso_word"}, got, exp_word);
    check({tag, "_busy_oe_during"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_oe_after"}, {30'd0, busy, miso_oe}, 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'(rx_data_m));
    check({tag, "_events_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mo;
    bit          flag;
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    sample_in = '0; sample_load = 1'b0;
    hold_m = '0; rx_data_m = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {9'd0, miso, miso_oe, busy, rx_valid, frame_err, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    load(12'hA5C);
    frame_check("readback", 32'h3C81, 16, -1, '0);

    load(12'hFFF);
    frame_check("b2b_fff", 32'($urandom), 16, -1, '0);
    load(12'h001);
    frame_check("b2b_001", 32'($urandom), 16, -1, '0);

    load(12'($urandom));
    frame_check("abort", 32'h1FF, 9, -1, '0);
    frame_check("after_abort", 32'($urandom), 16, -1, '0);

    load(12'h123);
    frame_check("collision", 32'($urandom), 16, -2, 12'h456);
    frame_check("midload", 32'($urandom), 16, 8, 12'h789);
    frame_check("after_midload", 32'($urandom), 16, -1, '0);

    frame_check("overlength", 32'($urandom), 20, -1, '0);

    flag = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mosi = 1'($urandom);
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      if (miso_oe !== 1'b0 || miso !== 1'b0 || busy !== 1'b0) flag = 1'b0;
      sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("idle_sck_quiet", 32'(flag), 32'd1);
    check("idle_rx_data", 32'(rx_data), 32'(rx_data_m));

    load(12'($urandom));
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'($urandom);
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {30'd0, busy, miso_oe}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("reset_midframe", {9'd0, miso, miso_oe, busy, rx_valid, frame_err, rx_data}, 32'd0);
    hold_m = '0; rx_data_m = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      if (busy !== 1'b0 || miso_oe !== 1'b0) flag = 1'b0;
      sck = 1'b0;
    end
    check("no_resume_after_reset", 32'(flag), 32'd1);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    frame_check("post_reset", 32'($urandom), 16, -1, '0);

    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) load(12'($urandom));
      mo = $urandom;
      if ($urandom_range(0, 4) == 0)
        frame_check("rand_abort", mo, $urandom_range(1, 15), -1, '0);
      else
        frame_check("rand_frame", mo, 16, -1, '0);
    end

    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
